// File: rtl/fht_loader_pkg.sv
// Shared definitions for the FHT input loader: state encoding, ack timeout and bit-reversal helper.
package fht_loader_pkg;

    typedef enum logic [1:0] {
        StLoad     = 2'd0,
        StStart    = 2'd1,
        StWaitAck  = 2'd2,
        StWaitDone = 2'd3
    } state_t;

    // Cycles to wait for the core to drop its ready before re-pulsing start.
    localparam int unsigned ACK_TMO = 4;

    localparam int unsigned BITREV_MAX = 32;

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                     input int w);
        logic [BITREV_MAX-1:0] r;
        r = '0;
        for (int b = 0; b < BITREV_MAX; b++) begin
            if (b < w) begin
                r[w-1-b] = v[b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_addr_gen.sv
// Maps a frame sample index to its RAM(A) bank and bank address.
// FHT_LOADER_BITREV_EN selects bit-reversed scatter; otherwise natural order is used.
module fht_addr_gen
    import fht_loader_pkg::*;
#(
    parameter int unsigned A_BIT = 8
) (
    input  logic [A_BIT+1:0] idx,
    output logic [1:0]       bank,
    output logic [A_BIT-1:0] addr
);

    localparam int unsigned I_BIT = A_BIT + 2;

    logic [I_BIT-1:0] r;

`ifdef FHT_LOADER_BITREV_EN
    assign r = I_BIT'(bitrev(BITREV_MAX'(idx), I_BIT));
`else
    assign r = idx;
`endif

    assign bank = r[A_BIT+1:A_BIT];
    assign addr = r[A_BIT-1:0];

endmodule

// File: rtl/fht_loader.sv
// Loads one N-sample frame into the FHT core's four RAM(A) banks, then starts and tracks the core.
// Scatter order is set by FHT_LOADER_BITREV_EN (see fht_addr_gen).
module fht_loader
    import fht_loader_pkg::*;
#(
    parameter int unsigned N     = 1024,
    parameter int unsigned D_BIT = 17,
    parameter int unsigned A_BIT = 8
) (
    input  logic               iCLK,
    input  logic               iRESET,
    input  logic [D_BIT-2:0]   iSAMPLE,
    input  logic               iVALID,
    input  logic               iFHT_RDY,
    input  logic               iCLR_OVF,
    output logic [D_BIT-2:0]   oDATA,
    output logic [A_BIT-1:0]   oADDR_WR,
    output logic               oWE_0,
    output logic               oWE_1,
    output logic               oWE_2,
    output logic               oWE_3,
    output logic               oSTART,
    output logic               oBUSY,
    output logic               oOVERFLOW,
    output logic [15:0]        oFRAME_CNT
);

    localparam int unsigned I_BIT   = $clog2(N);
    localparam int unsigned TMO_BIT = $clog2(ACK_TMO);

    state_t               state_q, state_d;
    logic [I_BIT-1:0]     idx_q, idx_d;
    logic [TMO_BIT-1:0]   tmo_q, tmo_d;
    logic [D_BIT-2:0]     data_q, data_d;
    logic [A_BIT-1:0]     addr_q, addr_d;
    logic [3:0]           we_q, we_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [1:0]           bank;
    logic [A_BIT-1:0]     addr;
    logic                 drop;

    fht_addr_gen #(
        .A_BIT(A_BIT)
    ) u_addr_gen (
        .idx (idx_q),
        .bank(bank),
        .addr(addr)
    );

    assign drop = iVALID && (state_q != StLoad);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        data_d  = data_q;
        addr_d  = addr_q;
        we_d    = '0;
        start_d = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            StLoad: begin
                if (iVALID) begin
                    we_d[bank] = 1'b1;
                    data_d     = iSAMPLE;
                    addr_d     = addr;
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == I_BIT'(N - 1)) begin
                        state_d = StStart;
                    end
                end
            end
            StStart: begin
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (!iFHT_RDY) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TMO_BIT'(ACK_TMO - 1)) begin
                    // Core missed the strobe: pulse again and restart the window.
                    start_d = 1'b1;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (iFHT_RDY) begin
                    state_d = StLoad;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = StLoad;
        endcase

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (iCLR_OVF) begin
            ovf_d = 1'b0;
        end

        busy_d = (state_d != StLoad);
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q <= StLoad;
            idx_q   <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            we_q    <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oDATA      = data_q;
    assign oADDR_WR   = addr_q;
    assign oWE_0      = we_q[0];
    assign oWE_1      = we_q[1];
    assign oWE_2      = we_q[2];
    assign oWE_3      = we_q[3];
    assign oSTART     = start_q;
    assign oBUSY      = busy_q;
    assign oOVERFLOW  = ovf_q;
    assign oFRAME_CNT = cnt_q;

endmodule

// File: tb/tb_fht_loader.sv
// Bench for fht_loader (N=16): directed scenarios plus random traffic against a frame-level model.
module tb_fht_loader;

    localparam int unsigned N     = 16;
    localparam int unsigned D_BIT = 17;
    localparam int unsigned A_BIT = 2;
    localparam int          LOG2N = 4;
    localparam int          BANK_SZ = N / 4;

    logic        iCLK = 1'b0;
    logic        iRESET = 1'b1;
    logic [15:0] iSAMPLE = '0;
    logic        iVALID = 1'b0;
    logic        iFHT_RDY = 1'b1;
    logic        iCLR_OVF = 1'b0;
    logic [15:0] oDATA;
    logic [1:0]  oADDR_WR;
    logic        oWE_0, oWE_1, oWE_2, oWE_3;
    logic        oSTART, oBUSY, oOVERFLOW;
    logic [15:0] oFRAME_CNT;

    fht_loader #(
        .N(N),
        .D_BIT(D_BIT),
        .A_BIT(A_BIT)
    ) dut (
        .iCLK      (iCLK),
        .iRESET    (iRESET),
        .iSAMPLE   (iSAMPLE),
        .iVALID    (iVALID),
        .iFHT_RDY  (iFHT_RDY),
        .iCLR_OVF  (iCLR_OVF),
        .oDATA     (oDATA),
        .oADDR_WR  (oADDR_WR),
        .oWE_0     (oWE_0),
        .oWE_1     (oWE_1),
        .oWE_2     (oWE_2),
        .oWE_3     (oWE_3),
        .oSTART    (oSTART),
        .oBUSY     (oBUSY),
        .oOVERFLOW (oOVERFLOW),
        .oFRAME_CNT(oFRAME_CNT)
    );

    always #5 iCLK = ~iCLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: samples so far in frame, what the core handshake is doing, last start cycle.
    int          m_idx = 0, m_phase = 0, m_cyc = 0, m_last = 0, m_cnt = 0;
    bit          m_ovf = 0;
    logic [3:0]  e_we = '0;
    logic [1:0]  e_addr = '0;
    logic [15:0] e_data = '0;
    bit          e_start = 0;

    function automatic int ref_slot(input int i);
        int r, v;
        r = 0;
        v = i;
`ifdef FHT_LOADER_BITREV_EN
        for (int k = 0; k < LOG2N; k++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
`else
        r = v;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_phase = 0; m_last = 0; m_cnt = 0; m_ovf = 0;
        e_we = '0; e_addr = '0; e_data = '0; e_start = 0;
    endtask

    function automatic logic [3:0] obs_we();
        return {oWE_3, oWE_2, oWE_1, oWE_0};
    endfunction

    // One clock: advance the model on the same inputs, then compare every output.
    task automatic tick();
        bit drop;
        int r;
        logic [40:0] exp_v, obs_v;
        @(posedge iCLK);
        m_cyc++;
        if (!iRESET) begin
            model_reset();
        end else begin
            drop = iVALID && (m_phase != 0);
            e_we = '0;
            e_start = 0;
            case (m_phase)
                0: if (iVALID) begin
                    r = ref_slot(m_idx);
                    e_we = 4'b0001 << (r / BANK_SZ);
                    e_addr = 2'(r % BANK_SZ);
                    e_data = iSAMPLE;
                    if (m_idx == N - 1) begin m_idx = 0; m_phase = 1; end
                    else m_idx++;
                end
                1: begin e_start = 1; m_last = m_cyc; m_phase = 2; end
                2: if (!iFHT_RDY) m_phase = 3;
                   else if (m_cyc - m_last == 4) begin e_start = 1; m_last = m_cyc; end
                default: if (iFHT_RDY) begin m_phase = 0; m_cnt++; end
            endcase
            if (drop) m_ovf = 1;
            else if (iCLR_OVF) m_ovf = 0;
        end
        #1;
        exp_v = {e_we, e_addr, e_data, e_start, (m_phase != 0), m_ovf, 16'(m_cnt)};
        obs_v = {obs_we(), oADDR_WR, oDATA, oSTART, oBUSY, oOVERFLOW, oFRAME_CNT};
        n_cmp++;
        if (obs_v !== exp_v) begin
            n_bad++;
            $display("FAIL model cyc %0d: got %h want %h", m_cyc, obs_v, exp_v);
        end
    endtask

    task automatic test_reset();
        #2 iRESET = 1'b0;
        #1;
        n_cmp++;
        if ({obs_we(), oADDR_WR, oDATA, oSTART, oBUSY, oOVERFLOW, oFRAME_CNT} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {obs_we(), oADDR_WR, oDATA, oSTART, oBUSY, oOVERFLOW, oFRAME_CNT});
        end
        tick();
        tick();
        iRESET = 1'b1;
    endtask

    task automatic test_frame();
        logic [3:0] w_we;
        logic [1:0] w_a;
        bit         chk;
        iFHT_RDY = 1'b1;
        for (int i = 0; i < N; i++) begin
            iVALID = 1'b1;
            iSAMPLE = 16'(i);
            tick();
            chk = 1;
`ifdef FHT_LOADER_BITREV_EN
            case (i)
                1: begin w_we = 4'b0100; w_a = 2'd0; end
                3: begin w_we = 4'b1000; w_a = 2'd0; end
                5: begin w_we = 4'b0100; w_a = 2'd2; end
                15: begin w_we = 4'b1000; w_a = 2'd3; end
                default: chk = 0;
            endcase
`else
            case (i)
                1: begin w_we = 4'b0001; w_a = 2'd1; end
                3: begin w_we = 4'b0001; w_a = 2'd3; end
                5: begin w_we = 4'b0010; w_a = 2'd1; end
                15: begin w_we = 4'b1000; w_a = 2'd3; end
                default: chk = 0;
            endcase
`endif
            if (chk) begin
                n_cmp++;
                if ({obs_we(), oADDR_WR, oDATA} !== {w_we, w_a, 16'(i)}) begin
                    n_bad++;
                    $display("FAIL scatter sample %0d: got we=%b a=%0d d=%0d want we=%b a=%0d",
                             i, obs_we(), oADDR_WR, oDATA, w_we, w_a);
                end
            end
        end
        iVALID = 1'b0;
        tick();
        n_cmp++;
        if ({oSTART, obs_we()} !== 5'b1_0000) begin
            n_bad++;
            $display("FAIL start_after_last_write: got start=%b we=%b want 1/0000",
                     oSTART, obs_we());
        end
    endtask

    task automatic test_ack_timeout();
        int starts;
        starts = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= 4) begin
                n_cmp++;
                if (oSTART !== (k == 4)) begin
                    n_bad++;
                    $display("FAIL ack_repulse k=%0d: got %b want %b", k, oSTART, (k == 4));
                end
            end
        end
        iFHT_RDY = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            starts += int'(oSTART);
        end
        n_cmp++;
        if (starts != 0 || oBUSY !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_done_entry: got starts=%0d busy=%b want 0/1", starts, oBUSY);
        end
    endtask

    task automatic test_drops();
        int writes;
        writes = 0;
        for (int k = 0; k < 3; k++) begin
            iVALID = 1'b1;
            iSAMPLE = 16'(k + 100);
            tick();
            writes += int'(obs_we() != 4'b0000);
        end
        iVALID = 1'b0;
        n_cmp++;
        if (writes != 0 || oOVERFLOW !== 1'b1) begin
            n_bad++;
            $display("FAIL drop_in_wait_done: got writes=%0d ovf=%b want 0/1", writes, oOVERFLOW);
        end
        iFHT_RDY = 1'b1;
        tick();
        n_cmp++;
        if (oFRAME_CNT !== 16'd1) begin
            n_bad++;
            $display("FAIL frame_cnt: got %0d want 1", oFRAME_CNT);
        end
        for (int i = 0; i < N; i++) begin
            iVALID = 1'b1;
            iSAMPLE = 16'hABC0 + 16'(i);
            tick();
            if (i == 0) begin
                n_cmp++;
                if ({obs_we(), oADDR_WR, oDATA} !== {4'b0001, 2'd0, 16'hABC0}) begin
                    n_bad++;
                    $display("FAIL first_after_done: got we=%b a=%0d d=%h want 0001/0/abc0",
                             obs_we(), oADDR_WR, oDATA);
                end
            end
        end
        iSAMPLE = 16'h5555;
        iCLR_OVF = 1'b1;
        tick();
        n_cmp++;
        if (oOVERFLOW !== 1'b1) begin
            n_bad++;
            $display("FAIL set_wins_over_clear: got %b want 1", oOVERFLOW);
        end
        iVALID = 1'b0;
        tick();
        iCLR_OVF = 1'b0;
        n_cmp++;
        if (oOVERFLOW !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_ovf: got %b want 0", oOVERFLOW);
        end
        iFHT_RDY = 1'b0;
        tick();
        iFHT_RDY = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int starts;
        for (int i = 0; i < 7; i++) begin
            iVALID = 1'b1;
            iSAMPLE = 16'h7000 + 16'(i);
            tick();
        end
        iVALID = 1'b0;
        iRESET = 1'b0;
        #2;
        n_cmp++;
        if ({obs_we(), oADDR_WR, oDATA, oSTART, oBUSY, oOVERFLOW, oFRAME_CNT} !== 41'd0) begin
            n_bad++;
            $display("FAIL midframe_reset_outputs: got %h want 0",
                     {obs_we(), oADDR_WR, oDATA, oSTART, oBUSY, oOVERFLOW, oFRAME_CNT});
        end
        tick();
        iRESET = 1'b1;
        starts = 0;
        for (int i = 0; i < N; i++) begin
            iVALID = 1'b1;
            iSAMPLE = 16'h0100 + 16'(i);
            tick();
            starts += int'(oSTART);
            if (i == 0) begin
                n_cmp++;
                if ({obs_we(), oADDR_WR} !== {4'b0001, 2'd0}) begin
                    n_bad++;
                    $display("FAIL restart_index0: got we=%b a=%0d want 0001/0",
                             obs_we(), oADDR_WR);
                end
            end
        end
        iVALID = 1'b0;
        iFHT_RDY = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            starts += int'(oSTART);
        end
        n_cmp++;
        if (starts != 1) begin
            n_bad++;
            $display("FAIL single_start: got %0d want 1", starts);
        end
        iFHT_RDY = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int dly, busy_cnt;
        dly = -1;
        busy_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            iVALID = ($urandom_range(0, 3) != 0);
            iSAMPLE = 16'($urandom);
            iCLR_OVF = ($urandom_range(0, 15) == 0);
            if (busy_cnt > 0) begin
                iFHT_RDY = 1'b0;
                busy_cnt--;
            end else if (dly == 0) begin
                iFHT_RDY = 1'b0;
                busy_cnt = $urandom_range(1, 8);
                dly = -1;
            end else begin
                iFHT_RDY = 1'b1;
                if (dly > 0) dly--;
            end
            tick();
            if (oSTART && dly < 0 && busy_cnt == 0) dly = $urandom_range(0, 9);
        end
        iVALID = 1'b0;
        iCLR_OVF = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_ack_timeout();
        test_drops();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
